inst_fetch_arbiter: RTL and testbench
=====================================

Name: inst_fetch_arbiter

Overview:
- Owns the address port of the combinational instruction ROM (rom_case: 16-bit word address in, 32-bit instruction out, same cycle).
- Holds the fetch PC and buffers fetched words in a small queue feeding decode over a valid/ready handshake.
- Handles branch redirects.
- Shares the ROM with a debug readback port, with a bounded-wait starvation guard so fetch cannot lock debug out.

Parameters:
- DEPTH, 2, instruction queue entries (power of 2, ≥2)
- DBG_MAX_WAIT, 4, max cycles a pending debug request may be deferred by fetch (≥1)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_address  out  16  word address to rom_case
- rom_data  in  32  rom_case output for rom_address, same cycle
- halt  in  1  stop issuing fetches; queue still drains
- redirect  in  1  branch taken; flush and refetch
- redirect_address  in  16  new word PC
- inst_valid  out  1  queue head valid
- inst_data  out  32  queue head instruction
- inst_pc  out  16  word PC of inst_data
- inst_ready  in  1  decode accepts head
- dbg_req  in  1  debug read request
- dbg_address  in  16  debug word address
- dbg_valid  out  1  one-cycle pulse, dbg_data valid
- dbg_data  out  32  captured ROM word

Behaviour:
- Reset (async, immediate):
  - fetch_pc=0, queue count=0
  - inst_valid=0, inst_data=0, inst_pc=0
  - dbg_valid=0, dbg_data=0, wait counter=0
- Cycle terms:
  - pop = inst_valid & inst_ready
  - fetch_ok = !halt & !redirect & (count<DEPTH | pop)
- Debug arbitration (dbg_eligible = dbg_req & !dbg_valid):
  - Grant when dbg_eligible & (!fetch_ok | wait==DBG_MAX_WAIT).
  - On grant:
    - rom_address=dbg_address
    - dbg_data<=rom_data; dbg_valid=1 next cycle only
    - wait<=0
    - Fetch suppressed this cycle even if fetch_ok.
  - dbg_eligible but not granted: wait<=wait+1 (saturates at DBG_MAX_WAIT).
  - No request: wait<=0.
  - A cycle with dbg_valid=1 is never a grant cycle.
  - A held dbg_req therefore yields back-to-back reads at most every 2 cycles.
- Fetch, when fetch_ok and no debug grant:
  - rom_address=fetch_pc
  - Enqueue {rom_data, fetch_pc}.
  - fetch_pc<=fetch_pc+1, 16-bit wrap (16'hFFFF→16'h0000).
- rom_address when neither fetch nor debug: fetch_pc.
- Queue:
  - Circular FIFO, head registered to inst_data/inst_pc.
  - Push and pop in the same cycle with count==DEPTH is legal: count unchanged.
  - A pop when empty cannot occur (inst_valid=0).
  - inst_data/inst_pc hold their last values while inst_valid=0.
- Redirect (highest priority for fetch state):
  - Queue count<=0.
  - fetch_pc<=redirect_address.
  - No enqueue that cycle; a pop that cycle is discarded.
  - inst_valid=0 the next cycle.
  - First fetch at redirect_address occurs the next cycle, so inst_valid rises 2 cycles after redirect if not blocked.
  - A debug grant may still occur in the redirect cycle (fetch_ok=0).
- Halt:
  - No new fetches; queue drains by pops; fetch_pc holds.
  - Redirect during halt still flushes and loads fetch_pc.
- Latency: fetch to inst_valid is 1 cycle (queue registered).
- Reset mid-operation: all state cleared asynchronously, pending debug request dropped. Requester must re-request after reset_n rises.

Test Plan:
- Reset release, inst_ready=1, rom_case clock-test image → inst_pc 0,1,2 on consecutive cycles; inst_data at PC 0 = 32'hD2800027; inst_valid first high 1 cycle after reset_n rises.
- inst_ready=0 for 6 cycles → count reaches DEPTH=2, fetch_pc holds at 2, inst_data stays 32'hD2800027; on release, PCs 0,1,2,3 delivered with no gaps or duplicates.
- Redirect to 16'h001B while queue full → next cycle inst_valid=0; following cycle inst_pc=16'h001B, inst_data=32'hF84303E7; no stale PC 0/1 delivered.
- dbg_req, dbg_address=16'h0038, fetch running continuously with inst_ready=1 → grant after exactly 4 deferred cycles; dbg_valid pulses with dbg_data=32'hD60003E0; exactly one fetch bubble, fetch_pc unaffected.
- halt=1 with dbg_req held at address 0 → reads granted every 2 cycles, dbg_data=32'hD2800027 each time; fetch_pc constant; queue drains to empty.
- fetch_pc=16'hFFFF via redirect → next fetches are 16'hFFFF then 16'h0000 (data 32'hD60003E0, then 32'hD2800027); assert reset_n low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/inst_fetch_arbiter_if.sv
// Decode-side instruction handshake between the fetch arbiter and decode.
// The arbiter presents the queue head; decode accepts it with inst_ready.
interface inst_fetch_arbiter_if;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;

  modport master (
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch_arbiter.sv
// Instruction fetch arbiter: owns the combinational ROM address port, keeps
// the fetch PC, buffers fetched words for decode and shares the ROM with a
// debug readback port that has a bounded-wait guard against fetch starvation.
module inst_fetch_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic [15:0]          rom_address,
  input  logic [31:0]          rom_data,
  input  logic                 halt,
  input  logic                 redirect,
  input  logic [15:0]          redirect_address,
  inst_fetch_arbiter_if.master dec,
  input  logic                 dbg_req,
  input  logic [15:0]          dbg_address,
  output logic                 dbg_valid,
  output logic [31:0]          dbg_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(DBG_MAX_WAIT + 1);

  logic [31:0]   q_data [DEPTH];
  logic [15:0]   q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0] count, count_next;
  logic [15:0]   fetch_pc;
  logic [WW-1:0] dbg_wait;

  logic        pop, fetch_ok, dbg_eligible, dbg_grant, do_fetch;
  logic [31:0] head_data;
  logic [15:0] head_pc;

  // Arbitration between fetch and debug, and the next queue head.
  // count includes the entry currently presented on inst_data/inst_pc, so the
  // registered head is rebuilt from the post-update read pointer; when the
  // entry being written lands on that slot it bypasses the storage array.
  always_comb begin
    pop          = dec.inst_valid & dec.inst_ready;
    fetch_ok     = !halt & !redirect & ((count < CW'(DEPTH)) | pop);
    dbg_eligible = dbg_req & !dbg_valid;
    dbg_grant    = dbg_eligible & (!fetch_ok | (dbg_wait == WW'(DBG_MAX_WAIT)));
    do_fetch     = fetch_ok & !dbg_grant;
    rom_address  = dbg_grant ? dbg_address : fetch_pc;
    rd_next      = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next   = count + CW'(do_fetch) - CW'(pop);
    if (do_fetch && (wr_ptr == rd_next)) begin
      head_data = rom_data;
      head_pc   = fetch_pc;
    end else begin
      head_data = q_data[rd_next];
      head_pc   = q_pc[rd_next];
    end
  end

  // Queue storage; contents are don't-care until counted valid.
  always_ff @(posedge clock) begin
    if (do_fetch) begin
      q_data[wr_ptr] <= rom_data;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

  // Fetch PC, queue pointers and registered head; redirect flushes everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc       <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      dec.inst_valid <= 1'b0;
      dec.inst_data  <= '0;
      dec.inst_pc    <= '0;
    end else if (redirect) begin
      fetch_pc       <= redirect_address;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      dec.inst_valid <= 1'b0;
    end else begin
      rd_ptr         <= rd_next;
      count          <= count_next;
      dec.inst_valid <= (count_next != '0);
      if (do_fetch) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 16'd1;
      end
      if (count_next != '0) begin
        dec.inst_data <= head_data;
        dec.inst_pc   <= head_pc;
      end
    end
  end

  // Debug capture, one-cycle valid pulse and saturating deferral counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dbg_valid <= 1'b0;
      dbg_data  <= '0;
      dbg_wait  <= '0;
    end else begin
      dbg_valid <= dbg_grant;
      if (dbg_grant) begin
        dbg_data <= rom_data;
        dbg_wait <= '0;
      end else if (dbg_eligible) begin
        if (dbg_wait != WW'(DBG_MAX_WAIT)) begin
          dbg_wait <= dbg_wait + WW'(1);
        end
      end else begin
        dbg_wait <= '0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Bench for inst_fetch_arbiter: directed scenarios followed by random
// stimulus, all checked against a queue-based reference model.
module tb_inst_fetch_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic        clock;
  logic        reset_n;
  logic [15:0] rom_address;
  logic [31:0] rom_data;
  logic        halt, redirect, ready, dbg_req;
  logic [15:0] redirect_address, dbg_address;
  logic        dbg_valid;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  inst_fetch_arbiter_if dec_if ();

  inst_fetch_arbiter #(.DEPTH(DEPTH), .DBG_MAX_WAIT(MAXW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rom_address      (rom_address),
    .rom_data         (rom_data),
    .halt             (halt),
    .redirect         (redirect),
    .redirect_address (redirect_address),
    .dec              (dec_if),
    .dbg_req          (dbg_req),
    .dbg_address      (dbg_address),
    .dbg_valid        (dbg_valid),
    .dbg_data         (dbg_data)
  );

  assign dec_if.inst_ready = ready;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM image: the words the scenarios rely on, unique filler elsewhere.
  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    case (a)
      16'h0000: return 32'hD2800027;
      16'h001B: return 32'hF84303E7;
      16'h0038: return 32'hD60003E0;
      16'hFFFF: return 32'hD60003E0;
      default:  return {a ^ 16'h5A5A, ~a};
    endcase
  endfunction

  always_comb rom_data = rom_fn(rom_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a list of {data, pc} entries visible to decode.
  typedef struct packed { logic [31:0] d; logic [15:0] pc; } ent_t;
  ent_t        m_q[$];
  logic [15:0] m_pc;
  int          m_wait;
  bit          m_dv;
  logic [31:0] m_dd, m_hd;
  logic [15:0] m_hpc;

  task automatic model_reset();
    m_q.delete();
    m_pc = 16'h0; m_wait = 0; m_dv = 0; m_dd = '0; m_hd = '0; m_hpc = '0;
  endtask

  // One clock: check the ROM address before the edge, advance the model,
  // then check registered outputs just after the edge.
  task automatic step();
    bit pop, fok, elig, grant;
    logic [15:0] exp_addr;
    ent_t e;
    @(negedge clock);
    pop   = (m_q.size() > 0) && ready;
    fok   = !halt && !redirect && ((m_q.size() < DEPTH) || pop);
    elig  = dbg_req && !m_dv;
    grant = elig && (!fok || (m_wait == MAXW));
    exp_addr = grant ? dbg_address : m_pc;
    chk("rom_address", rom_address, exp_addr);
    if (redirect) begin
      m_q.delete();
      m_pc = redirect_address;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (fok && !grant) begin
        e.d = rom_fn(m_pc); e.pc = m_pc;
        m_q.push_back(e);
        m_pc = m_pc + 16'd1;
      end
    end
    if (grant) m_dd = rom_fn(dbg_address);
    m_dv = grant;
    if (grant) m_wait = 0;
    else if (elig) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
    else m_wait = 0;
    if (m_q.size() > 0) begin
      m_hd  = m_q[0].d;
      m_hpc = m_q[0].pc;
    end
    @(posedge clock);
    #1;
    chk("inst_valid", dec_if.inst_valid, (m_q.size() > 0));
    chk("inst_data",  dec_if.inst_data,  m_hd);
    chk("inst_pc",    dec_if.inst_pc,    m_hpc);
    chk("dbg_valid",  dbg_valid,         m_dv);
    chk("dbg_data",   dbg_data,          m_dd);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    dbg_req = 1'b0;
    #1;
    chk("rst_inst_valid", dec_if.inst_valid, 0);
    chk("rst_inst_data",  dec_if.inst_data,  0);
    chk("rst_inst_pc",    dec_if.inst_pc,    0);
    chk("rst_dbg_valid",  dbg_valid,         0);
    chk("rst_dbg_data",   dbg_data,          0);
    chk("rst_rom_address", rom_address,      0);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int n, pulses;
    reset_n = 1'b0; halt = 0; redirect = 0; ready = 1; dbg_req = 0;
    redirect_address = '0; dbg_address = '0;
    model_reset();

    // Power-up reset, then fetch streams PCs 0,1,2.
    @(posedge clock);
    #1;
    apply_reset();
    chk("s1_valid_before", dec_if.inst_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s1_pc", dec_if.inst_pc, k);
      if (k == 0) chk("s1_data0", dec_if.inst_data, 32'hD2800027);
    end

    // Backpressure from a fresh reset: queue fills, fetch PC holds at 2.
    apply_reset();
    ready = 0;
    for (int k = 0; k < 6; k++) step();
    chk("s2_hold_pc",   rom_address,        16'd2);
    chk("s2_head_pc",   dec_if.inst_pc,     16'd0);
    chk("s2_head_data", dec_if.inst_data,   32'hD2800027);
    ready = 1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("s2_seq_pc", dec_if.inst_pc, k);
    end

    // Redirect while full.
    ready = 0;
    for (int k = 0; k < 3; k++) step();
    redirect = 1; redirect_address = 16'h001B; ready = 1;
    step();
    chk("s3_flush_valid", dec_if.inst_valid, 0);
    redirect = 0;
    step();
    chk("s3_valid", dec_if.inst_valid, 1);
    chk("s3_pc",    dec_if.inst_pc,    16'h001B);
    chk("s3_data",  dec_if.inst_data,  32'hF84303E7);

    // Debug against continuous fetch: deferred exactly DBG_MAX_WAIT cycles.
    dbg_req = 1; dbg_address = 16'h0038;
    n = 0;
    do begin
      step();
      n++;
    end while (!dbg_valid && n < 12);
    chk("s4_defer", n - 1, MAXW);
    chk("s4_data",  dbg_data, 32'hD60003E0);
    dbg_req = 0;
    step();

    // Halted: held debug request served every other cycle, queue drains.
    halt = 1; dbg_req = 1; dbg_address = 16'h0000;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (dbg_valid) begin
        pulses++;
        chk("s5_data", dbg_data, 32'hD2800027);
      end
    end
    chk("s5_pulses", pulses, 4);
    chk("s5_drained", dec_if.inst_valid, 0);
    halt = 0; dbg_req = 0;
    step();

    // PC wrap, then asynchronous reset mid-stream.
    redirect = 1; redirect_address = 16'hFFFF;
    step();
    redirect = 0;
    step();
    chk("s6_pc_ffff",   dec_if.inst_pc,   16'hFFFF);
    chk("s6_data_ffff", dec_if.inst_data, 32'hD60003E0);
    step();
    chk("s6_pc_0000",   dec_if.inst_pc,   16'h0000);
    chk("s6_data_0000", dec_if.inst_data, 32'hD2800027);
    #2;
    apply_reset();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      halt  = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0: redirect_address = 16'($urandom);
        1: redirect_address = 16'hFFFE;
        default: redirect_address = 16'h001B;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        dbg_req = ~dbg_req;
        dbg_address = 16'($urandom_range(0, 63));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
